// File: rtl/bf_prog_loader_if.sv
// rtl/bf_prog_loader_if.sv - source byte stream handshake between a byte source and the program loader
//
// Purpose: groups the valid/ready byte stream that carries Brainfuck source text.
// Signals:
//   i_byte_valid  source -> loader  a source byte is present
//   i_byte[7:0]   source -> loader  ASCII source byte
//   i_byte_last   source -> loader  marks the final byte; meaningful only with i_byte_valid
//   o_byte_ready  loader -> source  loader accepts a byte this cycle
// Modports: master = byte source, slave = loader.
interface bf_prog_loader_if;
  logic       i_byte_valid;
  logic [7:0] i_byte;
  logic       i_byte_last;
  logic       o_byte_ready;

  modport master (
    output i_byte_valid,
    output i_byte,
    output i_byte_last,
    input  o_byte_ready
  );

  modport slave (
    input  i_byte_valid,
    input  i_byte,
    input  i_byte_last,
    output o_byte_ready
  );
endinterface

// File: rtl/bf_prog_loader.sv
// rtl/bf_prog_loader.sv - encodes a Brainfuck source stream into 3-bit opcodes and loads program memory
//
// Purpose: accepts source bytes, writes one opcode per command character, checks bracket
// nesting against the loop-stack capacity, pads unused memory with NOPs and only then
// releases the core.
// Ports:
//   i_clock, i_reset_n   clock, asynchronous active-low reset
//   i_start              one-cycle pulse starting a load (ignored while loading/padding)
//   src (slave)          source byte stream (valid/ready/last)
//   o_prgmem_we/addr/data program memory write port, registered (1-cycle latency)
//   o_cpu_run, o_done    core enable / image complete, both high only in DONE
//   o_error, o_error_code load aborted and cause (00 too long, 01 unmatched ']',
//                        10 nesting overflow, 11 unclosed '[')
//   o_length             number of commands stored
module bf_prog_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  bf_prog_loader_if.slave              src,
  output logic                         o_prgmem_we,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [2:0]                   o_prgmem_data,
  output logic                         o_cpu_run,
  output logic                         o_done,
  output logic                         o_error,
  output logic [1:0]                   o_error_code,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_length
);

  localparam int P = PRGMEM_ADDR_WIDTH;
  localparam int S = STACK_ADDR_WIDTH;

  // count and depth are one bit wider than their address so that "full" is representable
  localparam logic [P:0]   MEM_FULL  = {1'b1, {P{1'b0}}};
  localparam logic [S:0]   DEPTH_MAX = {1'b1, {S{1'b0}}};
  localparam logic [P:0]   CNT_ONE   = {{P{1'b0}}, 1'b1};
  localparam logic [S:0]   DEP_ONE   = {{S{1'b0}}, 1'b1};
  localparam logic [P-1:0] LAST_ADDR = {P{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t       state;
  logic [P:0]   count;
  logic [S:0]   depth;
  logic [P-1:0] pad_ptr;

  logic [2:0]   opcode;
  logic         is_cmd;
  logic         is_open;
  logic         is_close;
  logic [S:0]   depth_next;
  logic [P:0]   count_next;

  always_comb begin
    opcode = 3'b000;
    case (src.i_byte)
      8'h2B:   opcode = 3'b011;  // '+'
      8'h2D:   opcode = 3'b010;  // '-'
      8'h3E:   opcode = 3'b101;  // '>'
      8'h3C:   opcode = 3'b100;  // '<'
      8'h5B:   opcode = 3'b111;  // '['
      8'h5D:   opcode = 3'b110;  // ']'
      default: opcode = 3'b000;  // comment byte
    endcase
  end

  assign is_cmd   = (opcode != 3'b000);
  assign is_open  = (opcode == 3'b111);
  assign is_close = (opcode == 3'b110);

  // depth/count as they will be after this byte, used by the end-of-source decision
  always_comb begin
    depth_next = depth;
    if (is_open) begin
      depth_next = depth + DEP_ONE;
    end else if (is_close) begin
      depth_next = depth - DEP_ONE;
    end
  end

  assign count_next = is_cmd ? (count + CNT_ONE) : count;

  assign src.o_byte_ready = (state == S_LOAD);
  assign o_length         = count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      count         <= '0;
      depth         <= '0;
      pad_ptr       <= '0;
      o_prgmem_we   <= 1'b0;
      o_prgmem_addr <= '0;
      o_prgmem_data <= 3'b000;
      o_cpu_run     <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_error_code  <= 2'b00;
    end else begin
      o_prgmem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state        <= S_LOAD;
            count        <= '0;
            depth        <= '0;
            o_cpu_run    <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_error_code <= 2'b00;
          end
        end

        S_LOAD: begin
          if (src.i_byte_valid) begin
            // the offending byte is never written
            if (is_cmd && count == MEM_FULL) begin
              state        <= S_ERROR;
              o_error      <= 1'b1;
              o_error_code <= 2'b00;
            end else if (is_close && depth == '0) begin
              state        <= S_ERROR;
              o_error      <= 1'b1;
              o_error_code <= 2'b01;
            end else if (is_open && depth == DEPTH_MAX) begin
              state        <= S_ERROR;
              o_error      <= 1'b1;
              o_error_code <= 2'b10;
            end else begin
              if (is_cmd) begin
                o_prgmem_we   <= 1'b1;
                o_prgmem_addr <= count[P-1:0];
                o_prgmem_data <= opcode;
                count         <= count_next;
                depth         <= depth_next;
              end
              if (src.i_byte_last) begin
                if (depth_next != '0) begin
                  state        <= S_ERROR;
                  o_error      <= 1'b1;
                  o_error_code <= 2'b11;
                end else if (count_next == MEM_FULL) begin
                  state     <= S_DONE;
                  o_done    <= 1'b1;
                  o_cpu_run <= 1'b1;
                end else begin
                  state   <= S_PAD;
                  pad_ptr <= count_next[P-1:0];
                end
              end
            end
          end
        end

        S_PAD: begin
          // count is left untouched so o_length keeps the command count
          o_prgmem_we   <= 1'b1;
          o_prgmem_addr <= pad_ptr;
          o_prgmem_data <= 3'b000;
          pad_ptr       <= pad_ptr + 1'b1;
          if (pad_ptr == LAST_ADDR) begin
            state     <= S_DONE;
            o_done    <= 1'b1;
            o_cpu_run <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// tb/tb_bf_prog_loader.sv - randomized self-checking bench for bf_prog_loader against a behavioural model
module tb_bf_prog_loader;
  localparam int P    = 8;
  localparam int S    = 4;
  localparam int MEM  = 1 << P;
  localparam int DMAX = 1 << S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         we;
  logic [P-1:0] addr;
  logic [2:0]   data;
  logic         run;
  logic         done;
  logic         err;
  logic [1:0]   code;
  logic [P:0]   len;

  bf_prog_loader_if bus ();

  bf_prog_loader #(.PRGMEM_ADDR_WIDTH(P), .STACK_ADDR_WIDTH(S)) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .src           (bus.slave),
    .o_prgmem_we   (we),
    .o_prgmem_addr (addr),
    .o_prgmem_data (data),
    .o_cpu_run     (run),
    .o_done        (done),
    .o_error       (err),
    .o_error_code  (code),
    .o_length      (len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // behavioural model: source -> expected write list and final outcome
  byte unsigned src_q[$];
  logic [10:0]  exp_wr[$];
  int           exp_err, exp_code, exp_len, n_use, exp_wait;

  function automatic logic [2:0] op_of(input byte unsigned b);
    case (b)
      "+": return 3'b011;
      "-": return 3'b010;
      ">": return 3'b101;
      "<": return 3'b100;
      "[": return 3'b111;
      "]": return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_run();
    int cnt = 0;
    int dep = 0;
    logic [2:0] op;
    int c;
    exp_wr.delete();
    exp_err  = 0;
    exp_code = 0;
    n_use    = src_q.size();
    for (int i = 0; i < src_q.size(); i++) begin
      op = op_of(src_q[i]);
      c  = -1;
      if (op != 3'b000) begin
        if (cnt == MEM) c = 0;
        else if (op == 3'b110 && dep == 0) c = 1;
        else if (op == 3'b111 && dep == DMAX) c = 2;
        else begin
          exp_wr.push_back({cnt[P-1:0], op});
          cnt++;
          if (op == 3'b111) dep++;
          if (op == 3'b110) dep--;
        end
      end
      if (c < 0 && i == src_q.size() - 1 && dep != 0) c = 3;
      if (c >= 0) begin
        exp_err  = 1;
        exp_code = c;
        n_use    = i + 1;
        break;
      end
    end
    exp_len = cnt;
    if (exp_err == 0) begin
      for (int a = cnt; a < MEM; a++) exp_wr.push_back({a[P-1:0], 3'b000});
      exp_wait = MEM - cnt + 1;
    end else begin
      exp_wait = 1;
    end
  endtask

  // compare process: every write strobe must match the next expected write
  bit         chk_en = 1'b0;
  logic [2:0] mem_img [MEM];
  logic [10:0] e;

  always @(negedge clk) begin
    if (chk_en) begin
      check("run_tracks_done", run, done);
      if (we) begin
        mem_img[addr] = data;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0d, required no write", addr, data);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", addr, e[10:3]);
          check("wr_data", data, e[2:0]);
        end
      end
    end
  end

  task automatic set_src(input string s);
    src_q.delete();
    for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
  endtask

  task automatic set_rep(input byte unsigned ch, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(ch);
  endtask

  task automatic do_start(input string name);
    for (int a = 0; a < MEM; a++) mem_img[a] = 3'b001;
    model_run();
    chk_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_ready_load"}, bus.o_byte_ready, 1);
    check({name, "_len_clr"}, len, 0);
    check({name, "_err_clr"}, err, 0);
  endtask

  task automatic do_stream(input string name, input int vpct);
    int i = 0;
    int guard = 0;
    while (i < n_use) begin
      guard++;
      if (guard > 5000) begin
        check({name, "_stream_timeout"}, i, n_use);
        break;
      end
      bus.i_byte_valid = ($urandom_range(99) < vpct);
      bus.i_byte       = src_q[i];
      bus.i_byte_last  = bus.i_byte_valid && (i == src_q.size() - 1);
      if (bus.i_byte_valid) begin
        check({name, "_ready"}, bus.o_byte_ready, 1);
        if (!bus.o_byte_ready) break;
        i++;
      end
      @(negedge clk);
    end
    bus.i_byte_valid = 1'b0;
    bus.i_byte_last  = 1'b0;
  endtask

  task automatic do_finish(input string name, output int k);
    k = 1;
    check({name, "_ready_off"}, bus.o_byte_ready, 0);
    if (exp_err != 0) begin
      check({name, "_error"}, err, 1);
      check({name, "_code"}, code, exp_code);
      check({name, "_done"}, done, 0);
    end else begin
      while (!done && k < 600) begin
        @(negedge clk);
        k++;
      end
      check({name, "_cycles_to_done"}, k, exp_wait);
      check({name, "_run"}, run, 1);
    end
    check({name, "_length"}, len, exp_len);
    repeat (3) @(negedge clk);
    check({name, "_writes_left"}, exp_wr.size(), 0);
    check({name, "_hold"}, {done, err}, (exp_err != 0) ? 1 : 2);
  endtask

  task automatic run_load(input string name, input int vpct, output int k);
    do_start(name);
    do_stream(name, vpct);
    do_finish(name, k);
  endtask

  string alpha = "+-<>[[]]a \n";
  int    k;
  int    n;

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_byte_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_flags", {run, done, err, code}, 0);
    check("rst_len", len, 0);
    check("rst_ready", bus.o_byte_ready, 0);
    rst_n = 1'b1;

    set_src("+[-]>");
    run_load("basic", 100, k);
    check("basic_pad_literal", k, 252);
    check("basic_m0", mem_img[0], 3);
    check("basic_m1", mem_img[1], 7);
    check("basic_m2", mem_img[2], 2);
    check("basic_m3", mem_img[3], 6);
    check("basic_m4", mem_img[4], 5);
    check("basic_m255", mem_img[255], 0);
    check("basic_len_literal", len, 5);

    set_src("a+ \n-");
    run_load("comment", 50, k);
    check("comment_len_literal", len, 2);
    check("comment_m0", mem_img[0], 3);
    check("comment_m1", mem_img[1], 2);
    check("comment_m2", mem_img[2], 0);

    set_src("]");
    run_load("unmatched", 100, k);
    check("unmatched_code_literal", code, 1);

    src_q.delete(); set_rep("[", 16); set_rep("]", 16);
    run_load("nest16", 70, k);
    check("nest16_done_literal", done, 1);

    src_q.delete(); set_rep("[", 17);
    run_load("nest17", 100, k);
    check("nest17_code_literal", code, 2);
    check("nest17_len_literal", len, 16);

    set_src("[[");
    run_load("unclosed", 100, k);
    check("unclosed_code_literal", code, 3);

    src_q.delete(); set_rep("+", 256);
    run_load("full", 100, k);
    check("full_direct_done", k, 1);

    src_q.delete(); set_rep("+", 257);
    run_load("toolong", 100, k);
    check("toolong_code_literal", code, 0);

    for (int t = 0; t < 8; t++) begin
      src_q.delete();
      n = $urandom_range(40, 1);
      for (int j = 0; j < n; j++) src_q.push_back(alpha[$urandom_range(alpha.len() - 1)]);
      run_load($sformatf("rand%0d", t), $urandom_range(100, 30), k);
    end

    // reset in the middle of padding
    set_src("+");
    do_start("rstpad");
    do_stream("rstpad", 100);
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstpad_we", we, 0);
    check("rstpad_addr", addr, 0);
    check("rstpad_flags", {run, done, err, code}, 0);
    check("rstpad_len", len, 0);
    check("rstpad_ready", bus.o_byte_ready, 0);
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_src("+");
    run_load("reload", 100, k);
    check("reload_len_literal", len, 1);
    check("reload_done_literal", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bf_prog_loader.md
# bf_prog_loader

Program loader for the brainhack core: accepts a Brainfuck source text as a byte stream over a valid/ready handshake and encodes each command character into the core's 3-bit opcode. It writes the opcodes into program memory, checks bracket nesting against the loop-stack capacity, and pads the unused memory with NOPs. It holds the core stopped until the image is complete and valid.

## Interface
- PRGMEM_ADDR_WIDTH, 8: program memory address width; capacity is 2^P entries.
- STACK_ADDR_WIDTH, 4: loop-stack address width; maximum nesting depth is 2^S.

Reset is asynchronous and active-low.

- i_clock  in  1  system clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that begins a load.
- i_byte_valid  in  1  source byte is present.
- i_byte  in  8  ASCII source byte.
- i_byte_last  in  1  qualifies the final byte of the source; valid only with i_byte_valid.
- o_byte_ready  out  1  loader accepts a byte this cycle.
- o_prgmem_we  out  1  program memory write strobe.
- o_prgmem_addr  out  P  program memory write address.
- o_prgmem_data  out  3  opcode to write.
- o_cpu_run  out  1  core enable; high only in DONE.
- o_done  out  1  image loaded and valid.
- o_error  out  1  load aborted.
- o_error_code  out  2  error cause; meaningful only while o_error is high.
- o_length  out  P+1  number of commands stored.

## Operation
- Opcode map: '+'=011, '-'=010, '>'=101, '<'=100, '['=111, ']'=110. NOP=000. Every other byte is a comment: it is accepted and discarded.
- States: IDLE, LOAD, PAD, DONE, ERROR. i_start is honoured in IDLE, DONE and ERROR, and ignored in LOAD and PAD.
- On i_start the loader enters LOAD and clears count, depth and error.
- LOAD:
  - o_byte_ready=1. A byte transfers when valid and ready are both high.
  - A command byte writes its opcode at address count, then count++.
  - '[' increments depth. ']' decrements depth.
- Errors, checked in priority order, on the offending byte; that byte is not written and the loader enters ERROR:
  - Command accepted while count==2^P: code 00 (TOO_LONG).
  - ']' while depth==0: code 01 (UNMATCHED).
  - '[' while depth==2^S: code 10 (NEST_OVF).
- On a transfer with i_byte_last:
  - The byte is processed as above.
  - Then depth!=0 gives ERROR code 11 (UNCLOSED).
  - Otherwise the loader enters PAD, or DONE if count==2^P.
- PAD: o_byte_ready=0. One NOP write per cycle at addresses count .. 2^P-1, then DONE. o_length keeps the command count.
- DONE: o_done=1, o_cpu_run=1. Memory is not written.
- ERROR: o_error=1, o_cpu_run=0. The state holds until i_start.
- Widths: count is P+1 bits, depth is S+1 bits. Neither wraps; the error checks prevent overflow.

## Timing
- Reset value of every output is 0; state resets to IDLE. Reset mid-LOAD or mid-PAD aborts immediately and leaves memory contents undefined.
- Write latency is 1 cycle: o_prgmem_we, addr and data are registered and assert the cycle after the transfer. o_prgmem_we is a single-cycle pulse per command.
- Throughput is one byte per cycle. o_byte_ready is combinational from state only, never from i_byte_valid.
- Entry into ERROR or PAD takes effect the cycle after the deciding transfer; o_byte_ready is 0 from that cycle on.
- PAD lasts 2^P-count cycles. DONE is entered the cycle after the final NOP write.
- o_done, o_error and o_cpu_run are registered and change in the cycle the state changes.
- An i_start pulse in DONE drops o_cpu_run the next cycle.

## Test plan
- Source "+[-]>" with last on '>':
  - Writes 011,111,010,110,101 at addresses 0-4.
  - Then NOPs at 5-255, 251 PAD cycles.
  - Then o_done=1, o_cpu_run=1, o_length=5.
- Source "a+ \n-", valid toggled randomly:
  - Exactly two writes: 011@0, 010@1.
  - Comment bytes produce no write; o_length=2.
- Source "]": no write; o_error=1, code 01, o_byte_ready=0 the next cycle.
- 16 '[' then 16 ']': loads OK. 17 '[': ERROR code 10 on the 17th; 16 writes done. "[[" with last: ERROR code 11.
- 256 '+' with last on the 256th: no PAD, DONE directly. 257 '+': ERROR code 00 on the 257th.
- Reset asserted mid-PAD: all outputs 0 asynchronously. A following i_start plus "+" reload reaches DONE with o_length=1.
